// File: rtl/sar_search_if.sv
// Comparator-facing bus of the successive-approximation search engine.
// The slave side is the search engine; the master side is whoever issues
// start requests and closes the loop through the magnitude comparator.
interface sar_search_if #(
    parameter int W = 8
) ();
    localparam int PW = $clog2(W + 2);

    logic          start;
    logic [2:0]    cmp_y;
    logic [W-1:0]  cand;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          found;
    logic          err;
    logic [PW-1:0] probes;

    modport master (
        output start,
        output cmp_y,
        input  cand,
        input  busy,
        input  done,
        input  result,
        input  found,
        input  err,
        input  probes
    );

    modport slave (
        input  start,
        input  cmp_y,
        output cand,
        output busy,
        output done,
        output result,
        output found,
        output err,
        output probes
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search engine. Drives a candidate into an external
// magnitude comparator (a = unknown target, b = cand), consumes the one-hot
// greater/equal/less answer and recovers the target bit by bit, MSB first.
// An equal answer ends the search early; otherwise a final VERIFY probe
// confirms the fully built value. Any non-one-hot answer aborts with err.
module sar_search #(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst,
    sar_search_if.slave bus
);
    localparam int KW = $clog2(W);
    localparam int PW = $clog2(W + 2);

    localparam logic [W-1:0]  ONE_W  = W'(32'd1);
    localparam logic [W-1:0]  ZERO_W = W'(32'd0);
    localparam logic [W-1:0]  MSB_W  = ONE_W << (W - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(32'd1);
    localparam logic [KW-1:0] K_ZERO = KW'(32'd0);
    localparam logic [KW-1:0] K_TOP  = KW'(W - 1);
    localparam logic [PW-1:0] P_ONE  = PW'(32'd1);
    localparam logic [PW-1:0] P_ZERO = PW'(32'd0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROBE  = 2'd1,
        ST_VERIFY = 2'd2
    } state_t;

    // True when exactly one of greater/equal/less is asserted.
    function automatic logic is_one_hot(input logic [2:0] y);
        logic oh;
        case (y)
            3'b001, 3'b010, 3'b100: oh = 1'b1;
            default:                oh = 1'b0;
        endcase
        return oh;
    endfunction

    state_t         state_r, state_nx_s;
    logic [KW-1:0]  k_r, k_nx_s;
    logic [W-1:0]   acc_r, acc_nx_s;
    logic [W-1:0]   cand_r, cand_nx_s;
    logic           busy_r, busy_nx_s;
    logic           done_r, done_nx_s;
    logic [W-1:0]   result_r, result_nx_s;
    logic           found_r, found_nx_s;
    logic           err_r, err_nx_s;
    logic [PW-1:0]  probes_r, probes_nx_s;

    logic [2:0]     y_s;
    logic [W-1:0]   bit_k_s;
    logic [W-1:0]   acc_upd_s;

    assign y_s = bus.cmp_y;

    // Next-state and next-datapath decode for one probe step.
    always_comb begin
        state_nx_s  = state_r;
        k_nx_s      = k_r;
        acc_nx_s    = acc_r;
        cand_nx_s   = cand_r;
        done_nx_s   = 1'b0;
        result_nx_s = result_r;
        found_nx_s  = found_r;
        err_nx_s    = err_r;
        probes_nx_s = probes_r;
        bit_k_s     = ONE_W << k_r;
        acc_upd_s   = acc_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    k_nx_s      = K_TOP;
                    acc_nx_s    = ZERO_W;
                    cand_nx_s   = MSB_W;
                    probes_nx_s = P_ONE;
                    result_nx_s = ZERO_W;
                    found_nx_s  = 1'b0;
                    err_nx_s    = 1'b0;
                    state_nx_s  = ST_PROBE;
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end

            ST_PROBE: begin
                if (!is_one_hot(y_s)) begin
                    result_nx_s = cand_r;
                    err_nx_s    = 1'b1;
                    found_nx_s  = 1'b0;
                    done_nx_s   = 1'b1;
                    state_nx_s  = ST_IDLE;
                end else if (y_s == 3'b010) begin
                    // Hit on the candidate itself: no need to resolve lower bits.
                    result_nx_s = cand_r;
                    found_nx_s  = 1'b1;
                    done_nx_s   = 1'b1;
                    state_nx_s  = ST_IDLE;
                end else begin
                    // target>cand keeps bit k; target<cand clears it.
                    if (y_s == 3'b100) begin
                        acc_upd_s = cand_r;
                    end else begin
                        acc_upd_s = cand_r & ~bit_k_s;
                    end
                    acc_nx_s    = acc_upd_s;
                    probes_nx_s = probes_r + P_ONE;
                    if (k_r != K_ZERO) begin
                        k_nx_s    = k_r - K_ONE;
                        cand_nx_s = acc_upd_s | (ONE_W << (k_r - K_ONE));
                    end else begin
                        // All bits decided; spend one more probe confirming them.
                        cand_nx_s  = acc_upd_s;
                        state_nx_s = ST_VERIFY;
                    end
                end
            end

            ST_VERIFY: begin
                result_nx_s = cand_r;
                done_nx_s   = 1'b1;
                state_nx_s  = ST_IDLE;
                if (!is_one_hot(y_s)) begin
                    err_nx_s   = 1'b1;
                    found_nx_s = 1'b0;
                end else begin
                    // A one-hot non-equal answer here means the comparator
                    // contradicted itself; report not found without err.
                    err_nx_s   = 1'b0;
                    found_nx_s = (y_s == 3'b010);
                end
            end

            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r      <= K_TOP;
            acc_r    <= ZERO_W;
            cand_r   <= ZERO_W;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO_W;
            found_r  <= 1'b0;
            err_r    <= 1'b0;
            probes_r <= P_ZERO;
        end else begin
            k_r      <= k_nx_s;
            acc_r    <= acc_nx_s;
            cand_r   <= cand_nx_s;
            busy_r   <= busy_nx_s;
            done_r   <= done_nx_s;
            result_r <= result_nx_s;
            found_r  <= found_nx_s;
            err_r    <= err_nx_s;
            probes_r <= probes_nx_s;
        end
    end

    assign bus.cand   = cand_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.found  = found_r;
    assign bus.err    = err_r;
    assign bus.probes = probes_r;
endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: W=8 and W=4 instances, each closed through an ideal
// comparator model, with an override on the W=8 loop to inject bad answers.
module tb_sar_search;
    logic clk;
    logic rst;

    sar_search_if #(.W(8)) if8 ();
    sar_search_if #(.W(4)) if4 ();

    logic [7:0] tgt8;
    logic [3:0] tgt4;
    logic       ovr_en;
    logic [2:0] ovr_y;

    assign if8.cmp_y = ovr_en ? ovr_y
                     : {tgt8 > if8.cand, tgt8 == if8.cand, tgt8 < if8.cand};
    assign if4.cmp_y = {tgt4 > if4.cand, tgt4 == if4.cand, tgt4 < if4.cand};

    sar_search #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    sar_search #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc8;
    logic [79:0] log_vec;

    // Probes an ideal comparator needs: the search hits equality on the probe
    // whose trial bit is the target's lowest set bit; zero needs all W+1.
    function automatic int model_probes(input int w, input int t);
        int n;
        if (t == 0) return w + 1;
        n = 0;
        while (((t >> n) & 1) == 0) n++;
        return w - n;
    endfunction

    // Runs one W=8 search from IDLE; logs every candidate shown while busy.
    task automatic run8(input logic [7:0] t, input int stray);
        tgt8 = t;
        log_vec = '0;
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        cyc8 = 0;
        while (if8.done !== 1'b1 && cyc8 < 20) begin
            if (if8.busy === 1'b1) log_vec = {log_vec[71:0], if8.cand};
            if8.start = (cyc8 == stray) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc8++;
        end
        if8.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; if8.start = 1'b0; if4.start = 1'b0;
        ovr_en = 1'b0; ovr_y = 3'b000; tgt8 = 8'd0; tgt4 = 4'd0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({if8.cand, if8.busy, if8.done, if8.result, if8.found, if8.err, if8.probes} !== 24'h0) begin
            $display("FAIL reset_w8: got cand=%0d busy=%b done=%b result=%0d found=%b err=%b probes=%0d expected all 0",
                     if8.cand, if8.busy, if8.done, if8.result, if8.found, if8.err, if8.probes);
        end else pass_cnt++;
        chk_cnt++;
        if ({if4.cand, if4.busy, if4.done, if4.probes} !== 9'h0) begin
            $display("FAIL reset_w4: got cand=%0d busy=%b done=%b probes=%0d expected all 0",
                     if4.cand, if4.busy, if4.done, if4.probes);
        end else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_early_exit();
        run8(8'd128, -1);
        chk_cnt++;
        if (cyc8 !== 1) $display("FAIL early_latency: got %0d cycles expected 1", cyc8);
        else pass_cnt++;
        chk_cnt++;
        if ({if8.result, if8.found, if8.err, if8.probes, if8.busy} !== {8'd128, 1'b1, 1'b0, 4'd1, 1'b0})
            $display("FAIL early_result: got result=%0d found=%b err=%b probes=%0d busy=%b expected 128 1 0 1 0",
                     if8.result, if8.found, if8.err, if8.probes, if8.busy);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({if8.done, if8.result, if8.found} !== {1'b0, 8'd128, 1'b1})
            $display("FAIL done_pulse: got done=%b result=%0d found=%b expected 0 128 1",
                     if8.done, if8.result, if8.found);
        else pass_cnt++;
    endtask

    task automatic test_sequences();
        logic [79:0] exp_seq [3];
        logic [7:0]  tg [3];
        int          np [3];
        tg[0] = 8'd0;   np[0] = 9; exp_seq[0] = 80'h00_80_40_20_10_08_04_02_01_00;
        tg[1] = 8'd255; np[1] = 8; exp_seq[1] = 80'h00_00_80_C0_E0_F0_F8_FC_FE_FF;
        tg[2] = 8'd85;  np[2] = 8; exp_seq[2] = 80'h00_00_80_40_60_50_58_54_56_55;
        for (int i = 0; i < 3; i++) begin
            run8(tg[i], -1);
            chk_cnt++;
            if (log_vec !== exp_seq[i])
                $display("FAIL cand_seq_%0d: got %h expected %h", tg[i], log_vec, exp_seq[i]);
            else pass_cnt++;
            chk_cnt++;
            if (cyc8 !== np[i] || {if8.result, if8.found, if8.err, if8.probes} !== {tg[i], 1'b1, 1'b0, 4'(np[i])})
                $display("FAIL seq_result_%0d: got cyc=%0d result=%0d found=%b err=%b probes=%0d expected cyc=%0d %0d 1 0 %0d",
                         tg[i], cyc8, if8.result, if8.found, if8.err, if8.probes, np[i], tg[i], np[i]);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_protocol_errors();
        // cmp_y=000 on probe 2
        tgt8 = 8'd50;
        if8.start = 1'b1; @(negedge clk); if8.start = 1'b0;
        @(negedge clk);
        ovr_en = 1'b1; ovr_y = 3'b000;
        @(negedge clk);
        chk_cnt++;
        if ({if8.done, if8.busy, if8.result, if8.found, if8.err, if8.probes} !== {1'b1, 1'b0, 8'd64, 1'b0, 1'b1, 4'd2})
            $display("FAIL err_000: got done=%b busy=%b result=%0d found=%b err=%b probes=%0d expected 1 0 64 0 1 2",
                     if8.done, if8.busy, if8.result, if8.found, if8.err, if8.probes);
        else pass_cnt++;
        ovr_en = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({if8.done, if8.err, if8.result} !== {1'b0, 1'b1, 8'd64})
            $display("FAIL err_hold: got done=%b err=%b result=%0d expected 0 1 64", if8.done, if8.err, if8.result);
        else pass_cnt++;

        // cmp_y=110 on probe 1
        if8.start = 1'b1; @(negedge clk); if8.start = 1'b0;
        ovr_en = 1'b1; ovr_y = 3'b110;
        @(negedge clk);
        chk_cnt++;
        if ({if8.done, if8.result, if8.found, if8.err, if8.probes} !== {1'b1, 8'd128, 1'b0, 1'b1, 4'd1})
            $display("FAIL err_110: got done=%b result=%0d found=%b err=%b probes=%0d expected 1 128 0 1 1",
                     if8.done, if8.result, if8.found, if8.err, if8.probes);
        else pass_cnt++;
        ovr_en = 1'b0;
        @(negedge clk);

        // inconsistent (one-hot but not equal) answer on the verify probe
        tgt8 = 8'd0;
        if8.start = 1'b1; @(negedge clk); if8.start = 1'b0;
        repeat (8) @(negedge clk);
        ovr_en = 1'b1; ovr_y = 3'b100;
        @(negedge clk);
        chk_cnt++;
        if ({if8.done, if8.result, if8.found, if8.err, if8.probes} !== {1'b1, 8'd0, 1'b0, 1'b0, 4'd9})
            $display("FAIL verify_inconsistent: got done=%b result=%0d found=%b err=%b probes=%0d expected 1 0 0 0 9",
                     if8.done, if8.result, if8.found, if8.err, if8.probes);
        else pass_cnt++;
        ovr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        run8(8'd85, 3);
        chk_cnt++;
        if (cyc8 !== 8 || {if8.result, if8.found, if8.err, if8.probes} !== {8'd85, 1'b1, 1'b0, 4'd8})
            $display("FAIL start_busy: got cyc=%0d result=%0d found=%b err=%b probes=%0d expected 8 85 1 0 8",
                     cyc8, if8.result, if8.found, if8.err, if8.probes);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_search();
        logic saw_done;
        tgt8 = 8'd200;
        if8.start = 1'b1; @(negedge clk); if8.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if ({if8.cand, if8.busy, if8.done, if8.result, if8.found, if8.err, if8.probes} !== 24'h0)
            $display("FAIL rst_async: got cand=%0d busy=%b done=%b result=%0d found=%b err=%b probes=%0d expected all 0",
                     if8.cand, if8.busy, if8.done, if8.result, if8.found, if8.err, if8.probes);
        else pass_cnt++;
        saw_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (if8.done === 1'b1 || if8.busy === 1'b1) saw_done = 1'b1;
        end
        chk_cnt++;
        if (saw_done !== 1'b0) $display("FAIL rst_no_done: got activity=%b expected 0", saw_done);
        else pass_cnt++;
        run8(8'h55, -1);
        chk_cnt++;
        if ({if8.result, if8.found, if8.err} !== {8'h55, 1'b1, 1'b0})
            $display("FAIL rst_then_search: got result=%0h found=%b err=%b expected 55 1 0",
                     if8.result, if8.found, if8.err);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int t, st, np;
        for (int i = 0; i < 30; i++) begin
            t  = $urandom_range(0, 255);
            st = $urandom_range(0, 9);
            np = model_probes(8, t);
            run8(8'(t), st);
            chk_cnt++;
            if (cyc8 !== np || {if8.result, if8.found, if8.err, if8.probes} !== {8'(t), 1'b1, 1'b0, 4'(np)})
                $display("FAIL random_%0d: got cyc=%0d result=%0d found=%b err=%b probes=%0d expected cyc=%0d %0d 1 0 %0d",
                         t, cyc8, if8.result, if8.found, if8.err, if8.probes, np, t, np);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_w8();
        int cyc, np;
        tgt8 = 8'd0;
        if8.start = 1'b1; @(negedge clk); if8.start = 1'b0;
        for (int t = 0; t < 256; t++) begin
            cyc = 0;
            while (if8.done !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            np = model_probes(8, t);
            chk_cnt++;
            if (cyc !== np || {if8.result, if8.found, if8.err, if8.probes} !== {8'(t), 1'b1, 1'b0, 4'(np)})
                $display("FAIL sweep8_%0d: got cyc=%0d result=%0d found=%b err=%b probes=%0d expected cyc=%0d %0d 1 0 %0d",
                         t, cyc, if8.result, if8.found, if8.err, if8.probes, np, t, np);
            else pass_cnt++;
            chk_cnt++;
            if (if8.probes > 4'd9) $display("FAIL sweep8_bound_%0d: got probes=%0d expected <=9", t, if8.probes);
            else pass_cnt++;
            if (t < 255) begin
                tgt8 = 8'(t + 1);
                if8.start = 1'b1; @(negedge clk); if8.start = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_w4();
        int cyc, np;
        tgt4 = 4'd0;
        if4.start = 1'b1; @(negedge clk); if4.start = 1'b0;
        for (int t = 0; t < 16; t++) begin
            cyc = 0;
            while (if4.done !== 1'b1 && cyc < 12) begin
                @(negedge clk);
                cyc++;
            end
            np = model_probes(4, t);
            chk_cnt++;
            if (cyc !== np || {if4.result, if4.found, if4.err, if4.probes} !== {4'(t), 1'b1, 1'b0, 3'(np)})
                $display("FAIL sweep4_%0d: got cyc=%0d result=%0d found=%b err=%b probes=%0d expected cyc=%0d %0d 1 0 %0d",
                         t, cyc, if4.result, if4.found, if4.err, if4.probes, np, t, np);
            else pass_cnt++;
            chk_cnt++;
            if (if4.probes > 3'd5) $display("FAIL sweep4_bound_%0d: got probes=%0d expected <=5", t, if4.probes);
            else pass_cnt++;
            if (t < 15) begin
                tgt4 = 4'(t + 1);
                if4.start = 1'b1; @(negedge clk); if4.start = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_early_exit();
        test_sequences();
        test_protocol_errors();
        test_start_while_busy();
        test_reset_mid_search();
        test_random();
        test_back_to_back_w8();
        test_back_to_back_w4();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/sar_search.md
# sar_search

Sequential successive-approximation search engine that drives the candidate input of an external magnitude comparator and consumes its one-hot greater/equal/less result to find an unknown target value in at most W+1 probes. The comparator sits outside this block with a = target and b = cand. The comparator's three-bit result (y[2] a>b, y[1] a=b, y[0] a<b) feeds back into this block. The block is the consumer end of the comparator interface and turns a relation into a value. It is used for threshold finding and value recovery where only comparison against the unknown is available.

## Interface
- W, default 8: width of target, candidate and result; W ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new search. Sampled only in IDLE and ignored while busy.
- cmp_y  in  3  comparator result for the current cand: [2] target>cand, [1] target=cand, [0] target<cand. Valid combinationally from cand in the same cycle.
- cand  out  W  candidate value driven to the comparator b input (registered).
- busy  out  1  high while a search is in progress (PROBE or VERIFY).
- done  out  1  one-cycle pulse when a search ends.
- result  out  W  search result, held from done until the next accepted start.
- found  out  1  high when cmp_y[1] was seen for result, held like result.
- err  out  1  high when the search aborted on a non-one-hot cmp_y, held like result.
- probes  out  $clog2(W+2)  number of probes used by the last search, held like result.

## Operation
- States: IDLE, PROBE, VERIFY.
- Internal registers: bit index k (0..W-1) and accumulated value acc (W bits).
- IDLE:
  - busy=0.
  - When start=1, load k=W-1, acc=0, cand=1<<(W-1), and probe count 1.
  - Clear found, err and result, then go to PROBE.
- PROBE, sampled at each clock edge:
  - If cmp_y is not exactly one-hot: result=cand, err=1, found=0, done=1, go to IDLE.
  - cmp_y=010 (equal): result=cand, found=1, done=1, go to IDLE (early exit).
  - cmp_y=100 (target>cand): keep bit k, so acc = cand.
  - cmp_y=001 (target<cand): clear bit k, so acc = cand with bit k cleared.
  - After a keep or clear with k>0: k=k-1, cand = acc | (1<<(k-1)), probe count +1.
  - After a keep or clear with k=0: cand = acc, probe count +1, go to VERIFY.
- VERIFY:
  - Any one-hot cmp_y: result=cand, done=1, go to IDLE. found=1 only if cmp_y=010, else found=0 (comparator inconsistent).
  - Non-one-hot cmp_y: result=cand, err=1, found=0, done=1, go to IDLE.
- cand holds its last value in IDLE; it is not cleared after a search.
- All arithmetic is unsigned, W bits. cand never exceeds 2^W−1 and no wrap is possible.

## Timing
- Reset (asynchronous, dominates everything) drives:
  - state=IDLE, k=W-1, acc=0.
  - cand=0, busy=0, done=0.
  - result=0, found=0, err=0, probes=0.
- Reset asserted mid-search abandons it immediately, with no done pulse.
- start sampled high at edge E0:
  - cand=2^(W-1) and busy=1 from E0.
  - Probe n is sampled at edge En.
- Done timing:
  - done is high for the single cycle after the deciding edge.
  - busy=0 in that same cycle, and result, found, err and probes are valid from that cycle.
- Latency:
  - Minimum, target=2^(W-1): done high in the cycle after E1.
  - Maximum: W+1 probes, done after E(W+1).
- Back-to-back:
  - start high in the done cycle is accepted (state is IDLE).
  - start high while busy has no effect.
- cmp_y must settle within the cycle after cand changes. There is no combinational path from cmp_y to any output.

## Test plan
- Reset mid-search with W=8: assert rst during probe 3 -> all outputs return to 0 and state is IDLE asynchronously, with no done pulse. A following start with target=0x55 -> result=0x55, found=1.
- Early exit, W=8, target=128: start -> cand=128, eq at E1 -> done in the cycle after E1, result=128, found=1, probes=1.
- Full-depth search, target=0: candidates are 128,64,32,16,8,4,2,1, then VERIFY with cand=0 -> result=0, found=1, probes=9, done after E9.
- Upper boundary and mid-value:
  - target=255: candidates are 128,192,224,240,248,252,254,255 -> result=255, found=1, probes=8.
  - target=85: candidates are 128,64,96,80,88,84,86,85 -> result=85, found=1, probes=8.
- Protocol errors:
  - Drive cmp_y=000 at probe 2 -> err=1, found=0, result=64, done pulse.
  - cmp_y=110 at probe 1 -> err=1, result=128.
  - start pulsed while busy -> ignored, and the search completes unchanged.
- Sweep with an ideal comparator model, W=4 and W=8: all targets searched back-to-back, with start issued in each done cycle -> result equals target, found=1, err=0, and probes ≤ W+1 every time.
